scalar_multiplication: RTL and testbench

SCALAR_MULTIPLICATION -- requirements
Module: scalar_multiplication

---
 rtl/ecc_pkg.sv | 22 ++
 rtl/scalar_bit_scanner.sv | 37 +++
 rtl/scalar_multiplication.sv | 165 ++++++++++++++++
 tb/tb_scalar_multiplication.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: state encoding and point-unit opcodes shared by scalar_multiplication
// and its bit scanner.
package ecc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      DBL_REQ,
      DBL_WAIT,
      ADD_REQ,
      ADD_WAIT,
      DONE
   } state_t;

   localparam logic OP_DBL = 1'b0;
   localparam logic OP_ADD = 1'b1;

   function automatic int idx_width(input int w);
      return w > 1 ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/scalar_bit_scanner.sv
// scalar_bit_scanner: holds the captured scalar and walks a bit index from n-1 down to 0,
// presenting the current bit and whether it is the last one.
module scalar_bit_scanner
   import ecc_pkg::*;
#(
   parameter int n = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic [n-1:0] k,
   output logic         bit_set,
   output logic         last
);

   localparam int IW = idx_width(n);

   logic [n-1:0]  k_r;
   logic [IW-1:0] idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_r <= '0;
         idx <= '0;
      end else if (load) begin
         k_r <= k;
         idx <= IW'(n - 1);
      end else if (step && idx != '0) begin
         idx <= idx - IW'(1);
      end
   end

   assign bit_set = k_r[idx];
   assign last    = idx == '0;

endmodule

// File: rtl/scalar_multiplication.sv
// scalar_multiplication: left-to-right double-and-add k*P driving an external point unit.
// Define ECC_SKIP_LEADING_ZEROS_EN to skip leading zero bits of k in the SCAN state.
module scalar_multiplication
   import ecc_pkg::*;
#(
   parameter int n = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] k,
   input  logic [n-1:0] p,
   input  logic [n-1:0] a,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] x_out,
   output logic [n-1:0] y_out,
   output logic         infinity,
   output logic         op_sel,
   output logic         op_reset,
   output logic [n-1:0] op_p,
   output logic [n-1:0] op_a,
   output logic [n-1:0] op_x1,
   output logic [n-1:0] op_y1,
   output logic [n-1:0] op_x2,
   output logic [n-1:0] op_y2,
   input  logic [n-1:0] op_x3,
   input  logic [n-1:0] op_y3,
   input  logic         op_result,
   input  logic         op_infinity
);

`ifdef ECC_SKIP_LEADING_ZEROS_EN
   localparam state_t FIRST = SCAN;
`else
   localparam state_t FIRST = DBL_REQ;
`endif

   state_t       state, state_nxt;
   logic [n-1:0] qx, qy, px, py, p_r, a_r, qx_nxt, qy_nxt;
   logic         q_inf, qinf_nxt, armed, armed_nxt;
   logic         load, step, bit_set, last, op_done, q_is_p;

   scalar_bit_scanner #(.n(n)) u_scan (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .step    (step),
      .k       (k),
      .bit_set (bit_set),
      .last    (last)
   );

   assign op_done  = op_result | op_infinity;
   assign q_is_p   = qx == px && qy == py;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign op_reset = (state == DBL_REQ || state == ADD_REQ) && !q_inf;
   // Q==P cannot go through the chord formula, so it is issued as a doubling
   assign op_sel   = (state == ADD_REQ || state == ADD_WAIT) && !q_is_p ? OP_ADD : OP_DBL;
   assign op_p     = p_r;
   assign op_a     = a_r;
   assign op_x1    = qx;
   assign op_y1    = qy;
   assign op_x2    = px;
   assign op_y2    = py;

   always_comb begin
      state_nxt = state;
      qx_nxt    = qx;
      qy_nxt    = qy;
      qinf_nxt  = q_inf;
      armed_nxt = armed;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            qx_nxt    = '0;
            qy_nxt    = '0;
            qinf_nxt  = 1'b1;
            state_nxt = k == '0 ? DONE : FIRST;
         end
         SCAN: begin
            qx_nxt    = bit_set ? px : qx;
            qy_nxt    = bit_set ? py : qy;
            qinf_nxt  = bit_set ? 1'b0 : q_inf;
            step      = !bit_set || !last;
            state_nxt = !bit_set ? SCAN : last ? DONE : DBL_REQ;
         end
         DBL_REQ: begin
            armed_nxt = 1'b0;
            step      = q_inf && !bit_set && !last;
            state_nxt = !q_inf ? DBL_WAIT : bit_set ? ADD_REQ : last ? DONE : DBL_REQ;
         end
         DBL_WAIT: begin
            armed_nxt = 1'b1;
            if (armed && op_done) begin
               qx_nxt    = op_x3;
               qy_nxt    = op_y3;
               qinf_nxt  = op_infinity;
               step      = !bit_set && !last;
               state_nxt = bit_set ? ADD_REQ : last ? DONE : DBL_REQ;
            end
         end
         ADD_REQ: begin
            armed_nxt = 1'b0;
            qx_nxt    = q_inf ? px : qx;
            qy_nxt    = q_inf ? py : qy;
            qinf_nxt  = 1'b0;
            step      = q_inf && !last;
            state_nxt = !q_inf ? ADD_WAIT : last ? DONE : DBL_REQ;
         end
         ADD_WAIT: begin
            armed_nxt = 1'b1;
            if (armed && op_done) begin
               qx_nxt    = op_x3;
               qy_nxt    = op_y3;
               qinf_nxt  = op_infinity;
               step      = !last;
               state_nxt = last ? DONE : DBL_REQ;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         qx       <= '0;
         qy       <= '0;
         q_inf    <= 1'b0;
         armed    <= 1'b0;
         px       <= '0;
         py       <= '0;
         p_r      <= '0;
         a_r      <= '0;
         x_out    <= '0;
         y_out    <= '0;
         infinity <= 1'b0;
      end else begin
         state <= state_nxt;
         qx    <= qx_nxt;
         qy    <= qy_nxt;
         q_inf <= qinf_nxt;
         armed <= armed_nxt;
         if (load) begin
            px  <= x;
            py  <= y;
            p_r <= p;
            a_r <= a;
         end
         if (state_nxt == DONE) begin
            x_out    <= qx_nxt;
            y_out    <= qy_nxt;
            infinity <= qinf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_scalar_multiplication.sv
// tb_scalar_multiplication: randomized scoreboard bench on y^2=x^3+2x+2 mod 17 with a
// 5-cycle behavioural point unit; reference k*P is computed by repeated point addition.
module tb_scalar_multiplication;

   localparam int N  = 10;
   localparam int PR = 17;
   localparam int CA = 2;

   typedef struct packed { bit isinf; int x; int y; } pt_t;
   typedef struct packed { pt_t pt; bit chk_ops; int ops; } exp_t;

   logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [N-1:0] k = '0, p = '0, a = '0, x = '0, y = '0;
   logic         busy, done, infinity, op_sel, op_reset, op_result, op_infinity;
   logic [N-1:0] x_out, y_out, op_p, op_a, op_x1, op_y1, op_x2, op_y2, op_x3, op_y3;

   int           vectors = 0, miscompares = 0;
   exp_t         sb[$];
   int           cnt = 0;
   pt_t          res;
   logic [6*N:0] snap;
   int           ops_cnt = 0;
   logic         op_prev = 1'b0;

   always #5 clk = ~clk;

   scalar_multiplication #(.n(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .k           (k),
      .p           (p),
      .a           (a),
      .x           (x),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .x_out       (x_out),
      .y_out       (y_out),
      .infinity    (infinity),
      .op_sel      (op_sel),
      .op_reset    (op_reset),
      .op_p        (op_p),
      .op_a        (op_a),
      .op_x1       (op_x1),
      .op_y1       (op_y1),
      .op_x2       (op_x2),
      .op_y2       (op_y2),
      .op_x3       (op_x3),
      .op_y3       (op_y3),
      .op_result   (op_result),
      .op_infinity (op_infinity)
   );

   function automatic int md(input int v);
      return ((v % PR) + PR) % PR;
   endfunction

   function automatic int inv(input int v);
      int r = 1;
      for (int i = 0; i < PR - 2; i++) r = md(r * v);
      return r;
   endfunction

   function automatic pt_t mk(input int px, input int py);
      pt_t r;
      r.isinf = 1'b0;
      r.x     = md(px);
      r.y     = md(py);
      return r;
   endfunction

   function automatic pt_t inf_pt();
      pt_t r = '0;
      r.isinf = 1'b1;
      return r;
   endfunction

   function automatic pt_t dbl(input pt_t q);
      int l, x3;
      if (q.isinf || q.y == 0) return inf_pt();
      l  = md((3 * q.x * q.x + CA) * inv(md(2 * q.y)));
      x3 = md(l * l - 2 * q.x);
      return mk(x3, l * (q.x - x3) - q.y);
   endfunction

   function automatic pt_t add(input pt_t u, input pt_t v);
      int l, x3;
      if (u.isinf) return v;
      if (v.isinf) return u;
      if (u.x == v.x) return md(u.y + v.y) == 0 ? inf_pt() : dbl(u);
      l  = md((v.y - u.y) * inv(md(v.x - u.x)));
      x3 = md(l * l - u.x - v.x);
      return mk(x3, l * (u.x - x3) - u.y);
   endfunction

   function automatic pt_t mul(input int kk, input pt_t b);
      pt_t r = inf_pt();
      for (int i = 0; i < kk; i++) r = add(r, b);
      return r;
   endfunction

   // point unit stand-in: an ADD with equal x yields infinity, so a misissued Q==P shows up
   function automatic pt_t unit(input logic sel, input int x1, input int y1, input int x2, input int y2);
      pt_t u = mk(x1, y1), v = mk(x2, y2);
      if (!sel) return dbl(u);
      return u.x == v.x ? inf_pt() : add(u, v);
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      logic [8*N+4:0] v;
      v = {busy, done, op_reset, op_sel, infinity, x_out, y_out, op_p, op_a, op_x1, op_y1, op_x2, op_y2};
      vectors++;
      if (v !== '0) begin
         miscompares++;
         $display("FAIL %s: outputs %h, expected all zero", nm, v);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= 0;
         op_result   <= 1'b0;
         op_infinity <= 1'b0;
         op_x3       <= '0;
         op_y3       <= '0;
      end else if (op_reset) begin
         cnt         <= 5;
         res         <= unit(op_sel, int'(op_x1), int'(op_y1), int'(op_x2), int'(op_y2));
         snap        <= {op_sel, op_x1, op_y1, op_x2, op_y2, op_p, op_a};
         op_result   <= 1'b0;
         op_infinity <= 1'b0;
      end else begin
         op_result   <= cnt == 1 && !res.isinf;
         op_infinity <= cnt == 1 && res.isinf;
         if (cnt == 1) begin
            op_x3 <= N'(res.x);
            op_y3 <= N'(res.y);
         end
         if (cnt > 0) cnt <= cnt - 1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         ops_cnt = 0;
         op_prev = 1'b0;
      end else begin
         if (op_reset) begin
            chk("op_reset_width", int'(op_prev), 0);
            if (!op_prev) ops_cnt++;
         end
         op_prev = op_reset;
         if (cnt > 0) begin
            vectors++;
            if ({op_sel, op_x1, op_y1, op_x2, op_y2, op_p, op_a} !== snap || op_p !== N'(PR) || op_a !== N'(CA)) begin
               miscompares++;
               $display("FAIL operand_hold: got %h, expected %h", {op_sel, op_x1, op_y1, op_x2, op_y2, op_p, op_a}, snap);
            end
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("infinity", int'(infinity), int'(e.pt.isinf));
               if (!e.pt.isinf) begin
                  chk("x_out", int'(x_out), e.pt.x);
                  chk("y_out", int'(y_out), e.pt.y);
               end
               if (e.chk_ops) chk("op_pulses", ops_cnt, e.ops);
            end
            ops_cnt = 0;
         end
      end
   end

   task automatic issue(input int kv, input pt_t b);
      @(posedge clk);
      #1;
      k     = N'(kv);
      x     = N'(b.x);
      y     = N'(b.y);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         got = done;
      end
      if (!got) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic run(input int kv, input pt_t b, input bit chk_ops);
      exp_t e;
      e.pt      = mul(kv, b);
      e.chk_ops = chk_ops;
      e.ops     = 0;
      sb.push_back(e);
      issue(kv, b);
      wait_done("run");
   endtask

   initial begin
      pt_t base, b;
      int  kv;
      bit  seen;
      base = mk(5, 1);
      #2 reset = 1'b0;
      #1 chk_zero("reset_state");
      p = N'(PR);
      a = N'(CA);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      run(2, base, 1'b0);
      run(5, base, 1'b0);
      run(19, base, 1'b0);
      run(0, base, 1'b1);
      run(1, base, 1'b1);
      run(21, base, 1'b0);
      run(1023, base, 1'b0);
      run(20, base, 1'b0);
      // a second start during the run must be ignored
      sb.push_back('{pt: mul(5, base), chk_ops: 1'b0, ops: 0});
      issue(5, base);
      repeat (3) @(posedge clk);
      #1 chk("busy_during_run", int'(busy), 1);
      k     = N'(2);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("ignored_start");
      repeat (40) @(posedge clk);
      // reset in DBL_WAIT of k=5 discards the run
      issue(5, base);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         seen = op_reset;
      end
      chk("first_launch_seen", int'(seen), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_zero("reset_mid_op");
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      run(2, base, 1'b0);
      for (int i = 0; i < 20; i++) begin
         b  = mul($urandom_range(1, 18), base);
         kv = $urandom_range(0, 1023);
         run(kv, b, kv <= 1);
      end
      repeat (20) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
